// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life seed/run controller.
//   statetype       : controller FSM encoding (matches the state_o output code)
//   DEFAULT_SEED_64 : board pattern loaded after reset and whenever idle
//   TAPS_64         : Galois feedback mask for x^64+x^63+x^61+x^60+1
package life_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LFSR  = 2'd1,
    PLAY  = 2'd2,
    PAUSE = 2'd3
  } statetype;

  localparam logic [63:0] DEFAULT_SEED_64 = 64'h0412_6424_0034_3C28;
  localparam logic [63:0] TAPS_64         = 64'hD800_0000_0000_0000;

endpackage

// File: rtl/life_seed_ctrl_lfsr.sv
// Free-running right-shifting Galois LFSR.
//   clk   : system clock
//   reset : synchronous, active-high; loads INIT
//   q     : current register value (advances every non-reset cycle)
// A nonzero INIT never reaches the all-zero state.
module galois_lfsr
  import life_pkg::*;
#(
  parameter int               WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_64),
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(DEFAULT_SEED_64)
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  // Bit shifted out of the bottom decides whether the feedback mask is applied.
  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/life_seed_ctrl.sv
// Seed and run controller for the Game-of-Life board.
//   clk       : system clock
//   reset     : synchronous, active-high
//   start     : pulse, begin play from IDLE or LFSR
//   randomize : pulse or level, enter/stay in LFSR (seed follows the LFSR)
//   pause     : pulse, toggle PLAY <-> PAUSE
//   seed      : registered board seed
//   load      : one-cycle pulse, board loads seed (IDLE/LFSR -> PLAY only)
//   step      : one-cycle pulse every STEP_DIV cycles of play
//   state_o   : 0 IDLE, 1 LFSR, 2 PLAY, 3 PAUSE
// Input priority when several arrive together: randomize > start > pause.
module life_seed_ctrl
  import life_pkg::*;
#(
  parameter int          WIDTH        = 64,
  parameter logic [63:0] DEFAULT_SEED = DEFAULT_SEED_64,
  parameter logic [63:0] LFSR_TAPS    = TAPS_64,
  parameter int          STEP_DIV     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             randomize,
  input  logic             pause,
  output logic [WIDTH-1:0] seed,
  output logic             load,
  output logic             step,
  output logic [1:0]       state_o
);

  localparam logic [WIDTH-1:0] SEED_W  = WIDTH'(DEFAULT_SEED);
  localparam logic [WIDTH-1:0] TAPS_W  = WIDTH'(LFSR_TAPS);
  localparam int               CW      = $clog2(STEP_DIV);
  localparam logic [CW-1:0]    CNT_MAX = CW'(STEP_DIV - 1);

  statetype         state_q, state_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;
  logic             load_q, load_d;
  logic             step_q, step_d;
  logic [WIDTH-1:0] lfsr_q;

  galois_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS_W),
    .INIT  (SEED_W)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    step_d  = 1'b0;
    cnt_inc = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        seed_d = SEED_W;
        if (randomize) begin
          state_d = LFSR;
        end else if (start) begin
          state_d = PLAY;
          load_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      LFSR: begin
        // Sample the LFSR on every edge, including the exit edge, so the
        // value frozen in seed is the one captured when start arrives.
        seed_d = lfsr_q;
        if (randomize) begin
          state_d = LFSR;
        end else if (start) begin
          state_d = PLAY;
          load_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      PLAY: begin
        if (randomize) begin
          state_d = LFSR;
          cnt_d   = '0;
        end else if (pause) begin
          // Leaving on a terminal count drops that step; cnt keeps its value.
          state_d = PAUSE;
        end else begin
          cnt_d  = cnt_inc;
          step_d = (cnt_q == CNT_MAX);
        end
      end
      PAUSE: begin
        if (randomize) begin
          state_d = LFSR;
          cnt_d   = '0;
        end else if (pause) begin
          // The resume edge is the first counted edge of the resumed run.
          state_d = PLAY;
          cnt_d   = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      seed_q  <= SEED_W;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      step_q  <= step_d;
    end
  end

  // Parameter sanity: a zero seed would lock the LFSR, and STEP_DIV < 2
  // leaves no room for a one-cycle step pulse.
  always_ff @(posedge clk) begin
    assert (SEED_W != '0) else $error("life_seed_ctrl: DEFAULT_SEED is zero");
    assert (STEP_DIV >= 2) else $error("life_seed_ctrl: STEP_DIV below 2");
  end

  assign seed    = seed_q;
  assign load    = load_q;
  assign step    = step_q;
  assign state_o = state_q;

endmodule
